// File: rtl/spiphy_mx.sv
// Full-duplex SPI master PHY: variable frame length, per-frame CPOL/CPHA and bit order,
// CS_W chip selects with optional chip-select hold between frames.
module spiphy_mx #(
    parameter int DATA_W = 32,
    parameter int CS_W   = 4,
    parameter int DIV_W  = 12,
    localparam int LEN_W = $clog2(DATA_W),
    localparam int SEL_W = (CS_W > 1) ? $clog2(CS_W) : 1
) (
    input  logic              spiphy_clock_i,
    input  logic              spiphy_reset_ni,
    input  logic              spiphy_start_i,
    input  logic [LEN_W-1:0]  spiphy_len_i,
    input  logic              spiphy_cpol_i,
    input  logic              spiphy_cpha_i,
    input  logic              spiphy_lsb_first_i,
    input  logic [SEL_W-1:0]  spiphy_cs_sel_i,
    input  logic              spiphy_cs_hold_i,
    input  logic [DIV_W-1:0]  spiphy_clkdiv_i,
    input  logic [DATA_W-1:0] spiphy_tx_data_i,
    output logic              spiphy_busy_o,
    output logic              spiphy_done_o,
    output logic [DATA_W-1:0] spiphy_rx_data_o,
    output logic              sck_o,
    output logic [CS_W-1:0]   cs_n_o,
    output logic              mosi_o,
    input  logic              miso_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSGAP,
        S_SETUP,
        S_XFER,
        S_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [1:0]          r_rstSync;
    logic                w_rstN;

    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    r_clkdiv;
    logic [LEN_W-1:0]    r_len;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_lsb;
    logic [SEL_W-1:0]    r_csSel;
    logic                r_csHold;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rxShift;
    logic [DATA_W-1:0]   r_rxData;
    logic                r_done;
    logic                r_sck;
    logic                r_mosi;
    logic [CS_W-1:0]     r_csN;
    logic                r_holdActive;
    logic [LEN_W:0]      r_edge;

    logic                w_busy;
    logic                w_tick;
    logic                w_startAcc;
    logic                w_enterSetup;
    logic                w_xferTick;
    logic                w_holdDone;
    logic                w_lead;
    logic                w_sample;
    logic                w_shiftOut;
    logic [LEN_W-1:0]    w_shiftIdx;
    logic [LEN_W-1:0]    w_bitIdx;
    logic [LEN_W-1:0]    w_rxPos;
    logic                w_lastEdge;
    logic                w_gapNeeded;

    logic                w_cfgCpol;
    logic                w_cfgCpha;
    logic                w_cfgLsb;
    logic [LEN_W-1:0]    w_cfgLen;
    logic [SEL_W-1:0]    w_cfgSel;
    logic [DATA_W-1:0]   w_cfgTx;
    logic                w_firstBit;

    // k-th bit on the wire: MSB-first walks tx[len] down, LSB-first walks tx[0] up
    function automatic logic f_txBit(input logic [DATA_W-1:0] tx, input logic [LEN_W-1:0] len,
                                     input logic lsb, input logic [LEN_W-1:0] k);
        return lsb ? tx[k] : tx[len - k];
    endfunction

    function automatic logic [CS_W-1:0] f_csDecode(input logic [SEL_W-1:0] sel);
        logic [CS_W-1:0] csN;
        csN = '1;
        for (int i = 0; i < CS_W; i++) begin
            if (sel == SEL_W'(i)) csN[i] = 1'b0;
        end
        return csN;
    endfunction

    // Reset asserts asynchronously but is released two clocks later, aligned to the clock
    always_ff @(posedge spiphy_clock_i or negedge spiphy_reset_ni) begin
        if (!spiphy_reset_ni) r_rstSync <= 2'b00;
        else                  r_rstSync <= {r_rstSync[0], 1'b1};
    end
    assign w_rstN = r_rstSync[1];

    assign w_bitIdx    = r_edge[LEN_W:1];
    assign w_lastEdge  = (r_edge == {r_len, 1'b1});
    assign w_gapNeeded = r_holdActive && (spiphy_cs_sel_i != r_csSel);
    assign w_rxPos     = r_lsb ? w_bitIdx : (r_len - w_bitIdx);

    // Entering SETUP straight from IDLE must use the live inputs, since they latch on that same edge
    assign w_cfgCpol  = (r_state == S_IDLE) ? spiphy_cpol_i      : r_cpol;
    assign w_cfgCpha  = (r_state == S_IDLE) ? spiphy_cpha_i      : r_cpha;
    assign w_cfgLsb   = (r_state == S_IDLE) ? spiphy_lsb_first_i : r_lsb;
    assign w_cfgLen   = (r_state == S_IDLE) ? spiphy_len_i       : r_len;
    assign w_cfgSel   = (r_state == S_IDLE) ? spiphy_cs_sel_i    : r_csSel;
    assign w_cfgTx    = (r_state == S_IDLE) ? spiphy_tx_data_i   : r_tx;
    assign w_firstBit = f_txBit(w_cfgTx, w_cfgLen, w_cfgLsb, LEN_W'(0));

    always_ff @(posedge spiphy_clock_i or negedge w_rstN) begin
        if (!w_rstN) r_state <= S_IDLE;
        else         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            S_IDLE:  if (spiphy_start_i) w_nextState = w_gapNeeded ? S_CSGAP : S_SETUP;
            S_CSGAP: if (w_tick) w_nextState = S_SETUP;
            S_SETUP: if (w_tick) w_nextState = S_XFER;
            S_XFER:  if (w_tick && w_lastEdge) w_nextState = S_HOLD;
            S_HOLD:  if (w_tick) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Even edge indices are leading edges; CPHA picks which of the pair samples and which shifts
    always_comb begin
        w_busy       = (r_state != S_IDLE);
        w_tick       = w_busy && (r_div == r_clkdiv);
        w_startAcc   = (r_state == S_IDLE) && spiphy_start_i;
        w_enterSetup = (w_startAcc && !w_gapNeeded) || ((r_state == S_CSGAP) && w_tick);
        w_xferTick   = (r_state == S_XFER) && w_tick;
        w_holdDone   = (r_state == S_HOLD) && w_tick;
        w_lead       = ~r_edge[0];
        w_sample     = w_xferTick && (w_lead ^ r_cpha);
        w_shiftOut   = w_xferTick && (r_cpha ? w_lead : (!w_lead && !w_lastEdge));
        w_shiftIdx   = r_cpha ? w_bitIdx : (w_bitIdx + 1'b1);
    end

    always_ff @(posedge spiphy_clock_i or negedge w_rstN) begin
        if (!w_rstN) begin
            r_div        <= '0;
            r_clkdiv     <= '0;
            r_len        <= '0;
            r_cpol       <= 1'b0;
            r_cpha       <= 1'b0;
            r_lsb        <= 1'b0;
            r_csSel      <= '0;
            r_csHold     <= 1'b0;
            r_tx         <= '0;
            r_rxShift    <= '0;
            r_rxData     <= '0;
            r_done       <= 1'b0;
            r_sck        <= 1'b0;
            r_mosi       <= 1'b0;
            r_csN        <= '1;
            r_holdActive <= 1'b0;
            r_edge       <= '0;
        end else begin
            r_done <= 1'b0;

            if ((r_state == S_IDLE) || w_tick) r_div <= '0;
            else                               r_div <= r_div + 1'b1;

            if (w_startAcc) begin
                r_clkdiv  <= spiphy_clkdiv_i;
                r_len     <= spiphy_len_i;
                r_cpol    <= spiphy_cpol_i;
                r_cpha    <= spiphy_cpha_i;
                r_lsb     <= spiphy_lsb_first_i;
                r_csSel   <= spiphy_cs_sel_i;
                r_csHold  <= spiphy_cs_hold_i;
                r_tx      <= spiphy_tx_data_i;
                r_rxShift <= '0;
                r_edge    <= '0;
                if (w_gapNeeded) begin
                    r_csN        <= '1;
                    r_holdActive <= 1'b0;
                end
            end

            if (w_enterSetup) begin
                r_sck <= w_cfgCpol;
                r_csN <= f_csDecode(w_cfgSel);
                if (!w_cfgCpha) r_mosi <= w_firstBit;
            end

            if (w_xferTick) begin
                r_sck  <= ~r_sck;
                r_edge <= r_edge + 1'b1;
            end
            if (w_sample)   r_rxShift[w_rxPos] <= miso_i;
            if (w_shiftOut) r_mosi <= f_txBit(r_tx, r_len, r_lsb, w_shiftIdx);

            if (w_holdDone) begin
                r_done       <= 1'b1;
                r_rxData     <= r_rxShift;
                r_holdActive <= r_csHold;
                if (!r_csHold) r_csN <= '1;
            end
        end
    end

    assign spiphy_busy_o    = w_busy;
    assign spiphy_done_o    = r_done;
    assign spiphy_rx_data_o = r_rxData;
    assign sck_o            = r_sck;
    assign cs_n_o           = r_csN;
    assign mosi_o           = r_mosi;

endmodule

// File: tb/tb_spiphy_mx.sv
// Directed bench for spiphy_mx: expected receive words go into a scoreboard queue,
// a monitor pops one per done pulse; timing, chip-select and reset behaviour checked inline.
module tb_spiphy_mx;

    localparam int DATA_W = 32;
    localparam int CS_W   = 4;
    localparam int DIV_W  = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [4:0]        len = '0;
    logic              cpol = 1'b0;
    logic              cpha = 1'b0;
    logic              lsbFirst = 1'b0;
    logic [1:0]        csSel = '0;
    logic              csHold = 1'b0;
    logic [DIV_W-1:0]  clkdiv = '0;
    logic [DATA_W-1:0] txData = '0;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rxData;
    logic              sck;
    logic [CS_W-1:0]   csN;
    logic              mosi;
    logic              miso;

    logic              loopEn = 1'b1;
    logic              patEn = 1'b0;
    logic              patCpol = 1'b0;
    logic              patMiso = 1'b0;
    logic [31:0]       pat = '0;
    int                patK = 0;

    logic [31:0]       expQ[$];
    int                checks = 0;
    int                errors = 0;
    int                doneCount = 0;
    int                expDones = 0;
    int                busyCycles = 0;
    int                multiLow = 0;
    int                sckRises = 0;
    logic [31:0]       mosiCap = '0;
    time               tRise1 = 0;
    time               tRise2 = 0;
    int                cs2Rises = 0;
    time               tCs2Rise = 0;
    time               tCs0Fall = 0;

    always #5 clk = ~clk;

    assign miso = loopEn ? mosi : patMiso;

    spiphy_mx #(.DATA_W(DATA_W), .CS_W(CS_W), .DIV_W(DIV_W)) dut (
        .spiphy_clock_i     (clk),
        .spiphy_reset_ni    (rst_n),
        .spiphy_start_i     (start),
        .spiphy_len_i       (len),
        .spiphy_cpol_i      (cpol),
        .spiphy_cpha_i      (cpha),
        .spiphy_lsb_first_i (lsbFirst),
        .spiphy_cs_sel_i    (csSel),
        .spiphy_cs_hold_i   (csHold),
        .spiphy_clkdiv_i    (clkdiv),
        .spiphy_tx_data_i   (txData),
        .spiphy_busy_o      (busy),
        .spiphy_done_o      (done),
        .spiphy_rx_data_o   (rxData),
        .sck_o              (sck),
        .cs_n_o             (csN),
        .mosi_o             (mosi),
        .miso_i             (miso)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: one scoreboard entry per done pulse, plus per-cycle bookkeeping
    always @(negedge clk) begin
        if (done === 1'b1) begin
            doneCount++;
            checkOutput("busyLowAtDone", 32'(busy), 32'd0);
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedDone: got rx 0x%0h, expected no done pulse", rxData);
            end else begin
                checkOutput("rxData", rxData, expQ.pop_front());
            end
        end
        if ($countones(~csN) > 1) multiLow++;
        if (busy === 1'b1) busyCycles++;
    end

    always @(posedge sck) begin
        if (sckRises == 0) tRise1 = $time;
        if (sckRises == 1) tRise2 = $time;
        sckRises++;
        mosiCap = {mosiCap[30:0], mosi};
    end

    // Simple slave: presents the next pattern bit on every leading SCK edge
    always @(sck) begin
        if (patEn && (sck !== patCpol) && (patK < 32)) begin
            patMiso = pat[patK];
            patK++;
        end
    end

    always @(posedge csN[2]) begin
        cs2Rises++;
        tCs2Rise = $time;
    end

    always @(negedge csN[0]) tCs0Fall = $time;

    task automatic applyStimulus(input int lenA, input int cpolA, input int cphaA, input int lsbA,
                                 input int selA, input int holdA, input int divA,
                                 input logic [31:0] tx, input logic [31:0] expRx, input bit expectDone);
        @(negedge clk);
        len        = 5'(lenA);
        cpol       = 1'(cpolA);
        cpha       = 1'(cphaA);
        lsbFirst   = 1'(lsbA);
        csSel      = 2'(selA);
        csHold     = 1'(holdA);
        clkdiv     = DIV_W'(divA);
        txData     = tx;
        sckRises   = 0;
        mosiCap    = '0;
        busyCycles = 0;
        patK       = 0;
        if (expectDone) begin
            expQ.push_back(expRx);
            expDones++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
        if (busy) checkOutput("frameTimeout", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sck"}, 32'(sck), 32'd0);
        checkOutput({tag, "_csN"}, 32'(csN), 32'hF);
        checkOutput({tag, "_mosi"}, 32'(mosi), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_rx"}, rxData, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneBefore;
        #2 rst_n = 1'b0;
        #10;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] mode 0, MSB-first, len=7, tx=0xA5 looped back");
        applyStimulus(7, 0, 0, 0, 0, 0, 1, 32'hA5, 32'hA5, 1'b1);
        waitIdle();
        checkOutput("m0_sckRises", 32'(sckRises), 32'd8);
        checkOutput("m0_mosiBits", mosiCap & 32'hFF, 32'hA5);
        checkOutput("m0_sckPeriod", 32'(tRise2 - tRise1), 32'd40);
        checkOutput("m0_busyCycles", 32'(busyCycles), 32'd36);

        $display("[TB] mode 3, LSB-first, len=15, slave returns 0xBEEF");
        loopEn  = 1'b0;
        patEn   = 1'b1;
        patCpol = 1'b1;
        pat     = 32'h0000BEEF;
        applyStimulus(15, 1, 1, 1, 0, 0, 2, 32'h1234, 32'hBEEF, 1'b1);
        waitIdle();
        checkOutput("m3_mosiBits", mosiCap & 32'hFFFF, 32'h2C48);
        checkOutput("m3_sckRises", 32'(sckRises), 32'd17);
        checkOutput("m3_sckIdle", 32'(sck), 32'd1);
        patEn  = 1'b0;
        loopEn = 1'b1;

        $display("[TB] mode 1, len=31, tx=0xDEADBEEF looped back");
        applyStimulus(31, 0, 1, 0, 1, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        waitIdle();
        checkOutput("m1_sckRises", 32'(sckRises), 32'd32);
        checkOutput("m1_sckIdle", 32'(sck), 32'd0);

        $display("[TB] len=0 single-bit frame");
        applyStimulus(0, 0, 0, 0, 3, 0, 0, 32'h3, 32'h1, 1'b1);
        waitIdle();
        checkOutput("len0_sckRises", 32'(sckRises), 32'd1);
        checkOutput("len0_busyCycles", 32'(busyCycles), 32'd4);

        $display("[TB] chip-select hold on index 2");
        applyStimulus(7, 0, 0, 0, 2, 1, 1, 32'h3C, 32'h3C, 1'b1);
        waitIdle();
        checkOutput("holdA_csN", 32'(csN), 32'hB);
        cs2Rises = 0;
        applyStimulus(7, 0, 0, 0, 2, 1, 1, 32'hC3, 32'hC3, 1'b1);
        waitIdle();
        checkOutput("holdB_cs2Rises", 32'(cs2Rises), 32'd0);
        checkOutput("holdB_csN", 32'(csN), 32'hB);
        applyStimulus(7, 0, 0, 0, 0, 0, 1, 32'h99, 32'h99, 1'b1);
        waitIdle();
        checkOutput("holdC_cs2Rises", 32'(cs2Rises), 32'd1);
        checkOutput("holdC_csGap", 32'(tCs0Fall - tCs2Rise), 32'd20);
        checkOutput("holdC_busyCycles", 32'(busyCycles), 32'd38);
        checkOutput("holdC_csN", 32'(csN), 32'hF);

        $display("[TB] start while busy is ignored");
        applyStimulus(7, 0, 0, 0, 1, 0, 1, 32'h11, 32'h11, 1'b1);
        repeat (5) @(negedge clk);
        txData = 32'hEE;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waitIdle();
        repeat (20) @(negedge clk);
        checkOutput("busyIgn_busy", 32'(busy), 32'd0);
        checkOutput("busyIgn_sckRises", 32'(sckRises), 32'd8);
        checkOutput("busyIgn_busyCycles", 32'(busyCycles), 32'd36);

        $display("[TB] reset asserted mid-transfer");
        applyStimulus(7, 0, 0, 0, 3, 0, 3, 32'hFF, 32'h0, 1'b0);
        for (int i = 0; i < 500 && sckRises < 2; i++) @(negedge clk);
        checkOutput("abort_midFrame", 32'(busy), 32'd1);
        doneBefore = doneCount;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkResetOutputs("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("abort_noDone", 32'(doneCount), 32'(doneBefore));

        $display("[TB] frame after reset");
        applyStimulus(7, 0, 0, 0, 1, 0, 1, 32'h5A, 32'h5A, 1'b1);
        waitIdle();
        checkOutput("post_sckRises", 32'(sckRises), 32'd8);

        checkOutput("doneCount", 32'(doneCount), 32'(expDones));
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("csOneLow", 32'(multiLow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spiphy_mx.md
Name: spiphy_mx

Overview:
- Parametrised successor to the single-channel SPI PHY.
- Full-duplex SPI master PHY with:
  - configurable frame length up to DATA_W bits;
  - CS_W chip selects;
  - per-frame CPOL/CPHA and MSB/LSB-first bit order;
  - optional chip-select hold across frames.
- Sits between the TileLink SPI register/FIFO front end and the pads. Takes one frame per start strobe and returns received data with a done pulse.

Parameters:
- DATA_W, 32, maximum frame length in bits (≥2).
- CS_W, 4, number of chip-select outputs (≥1).
- DIV_W, 12, width of the clock divider field.

Ports:
- spiphy_clock_i  in  1  system clock.
- spiphy_reset_ni  in  1  asynchronous active-low reset.
- spiphy_start_i  in  1  frame start strobe; accepted only when busy_o=0.
- spiphy_len_i  in  $clog2(DATA_W)  frame length minus 1 (0 → 1 bit).
- spiphy_cpol_i  in  1  idle SCK level.
- spiphy_cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge.
- spiphy_lsb_first_i  in  1  1: LSB transmitted and received first.
- spiphy_cs_sel_i  in  $clog2(CS_W) (min 1)  chip select index.
- spiphy_cs_hold_i  in  1  keep CS asserted after this frame.
- spiphy_clkdiv_i  in  DIV_W  SCK half-period minus 1, in system clocks.
- spiphy_tx_data_i  in  DATA_W  transmit data, right-justified.
- spiphy_busy_o  out  1  frame in progress.
- spiphy_done_o  out  1  one-cycle pulse at frame end.
- spiphy_rx_data_o  out  DATA_W  received data, right-justified, upper bits zero.
- sck_o  out  1  SPI clock.
- cs_n_o  out  CS_W  active-low chip selects.
- mosi_o  out  1  master out.
- miso_i  in  1  master in.

Behaviour:
- Reset (async assert, sync-safe release):
  - sck_o=0, cs_n_o=all 1, mosi_o=0;
  - busy_o=0, done_o=0, rx_data_o=0;
  - state IDLE, all counters 0.
- Reset mid-frame aborts immediately to reset values. There is no done pulse.
- On an accepted start, all config inputs and tx_data are latched; inputs may change afterwards. A start while busy is ignored.
- Half-period tick: the divider counts 0..clkdiv (latched). The tick fires when the count equals clkdiv, so the SCK half-period is clkdiv+1 clocks. clkdiv=0 gives SCK = clock/2.
- States:
  - IDLE → CSGAP: start with CS held on a different index. The held CS deasserts on entry; CSGAP lasts one half-period.
  - IDLE → SETUP: all other starts.
  - CSGAP → SETUP: on tick.
  - SETUP: selected cs_n low, sck_o=cpol. If CPHA=0, mosi_o = first bit. Lasts one half-period, then → XFER.
  - XFER: sck_o toggles on each tick, for 2*(len+1) edges.
    - CPHA=0: sample miso_i on leading edges; shift the next bit to mosi on trailing edges, except the last.
    - CPHA=1: shift on leading edges; sample on trailing edges.
    - After the final edge → HOLD.
  - HOLD: sck_o=cpol for one half-period, then → IDLE.
    - done_o pulses for 1 cycle and rx_data_o updates in the same cycle. rx_data_o is otherwise stable.
    - cs_n deasserts unless cs_hold was set.
- busy_o=1 in every state except IDLE. It falls in the same cycle done_o pulses.
- Bit order:
  - MSB-first transmits tx[len] down to tx[0].
  - LSB-first transmits tx[0] up to tx[len].
  - Received bits are placed so that rx[len:0] mirrors the transmit bit ordering; rx[DATA_W-1:len+1]=0.
- Held CS, same index on next start: proceeds directly to SETUP with CS kept low (no glitch).
- At most one cs_n bit is low at any time.
- cs_sel ≥ CS_W: frame runs with all cs_n high.
- mosi_o holds its last value between frames. SCK idles at the latched cpol after a frame; after reset it idles at 0 until the first start.

Test Plan:
- Mode 0, MSB-first, len=7, clkdiv=1, tx=0xA5, miso looped to mosi:
  - mosi shows 1,0,1,0,0,1,0,1;
  - 8 SCK rising edges with a period of 4 clocks;
  - rx=0x000000A5, done 1 cycle;
  - busy high for 2+16*2+2 = 36 clocks.
- Mode 3, LSB-first, len=15, tx=0x1234, miso driven with constant pattern 0xBEEF (LSB-first) → mosi order starts 0,0,1,0 and rx=0x0000BEEF.
- len=31, mode 1, tx=0xDEADBEEF looped → rx=0xDEADBEEF.
- len=0 → exactly 1 SCK pulse, rx=bit0.
- cs_hold on index 2:
  - a second frame on index 2 → cs_n_o[2] stays low throughout;
  - a third frame on index 0 → cs_n_o[2] rises, one half-period gap, then cs_n_o[0] falls;
  - never two cs_n low at once.
- Start asserted while busy → ignored.
- Reset asserted mid-XFER → all outputs return to reset values asynchronously, no done pulse.
- A new frame after reset completes normally.
